// File: rtl/port_desc_queue.sv
// Per-output-port descriptor queue manager.
// Keeps one circular FIFO of (SRAM address, packet length) descriptors per
// priority and hands them to the port read side. The next queue is picked by
// strict priority or weighted round robin.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   sp0_wrr1          selection mode: 0 strict priority, 1 WRR
//   wrr_weight        per-priority weight, priority p in [p*W +: W]
//   enq_vld/_priority/_address/_length   descriptor enqueue
//   enq_ready         combinational: target queue is not full
//   overflow          one-cycle pulse after a dropped enqueue
//   deq_req           read side asks for the next descriptor
//   deq_vld/_address/_length/_priority   registered dequeue result
//   prepared          some queue is non-empty
//   full, almost_full per-queue occupancy flags
module port_desc_queue #(
    parameter int unsigned num_of_priorities  = 8,
    parameter int unsigned priority_width     = 3,
    parameter int unsigned address_width      = 17,
    parameter int unsigned pack_length_width  = 8,
    parameter int unsigned queue_depth        = 16,
    parameter int unsigned depth_width        = 4,
    parameter int unsigned wrr_weight_width   = 5,
    parameter int unsigned almost_full_margin = 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          sp0_wrr1,
    input  logic [num_of_priorities*wrr_weight_width-1:0] wrr_weight,
    input  logic                                          enq_vld,
    input  logic [priority_width-1:0]                     enq_priority,
    input  logic [address_width-1:0]                      enq_address,
    input  logic [pack_length_width-1:0]                  enq_length,
    output logic                                          enq_ready,
    output logic                                          overflow,
    input  logic                                          deq_req,
    output logic                                          deq_vld,
    output logic [address_width-1:0]                      deq_address,
    output logic [pack_length_width-1:0]                  deq_length,
    output logic [priority_width-1:0]                     deq_priority,
    output logic                                          prepared,
    output logic [num_of_priorities-1:0]                  full,
    output logic [num_of_priorities-1:0]                  almost_full
);

    localparam int unsigned ptr_width = depth_width + 1;
    localparam int unsigned mem_depth = num_of_priorities * queue_depth;
    localparam int unsigned idx_width = priority_width + depth_width;

    typedef logic [ptr_width-1:0]        ptr_t;
    typedef logic [wrr_weight_width-1:0] credit_t;

    typedef struct packed {
        logic [address_width-1:0]     address;
        logic [pack_length_width-1:0] length;
    } desc_t;

    // Descriptor storage; queue p occupies rows [p*queue_depth +: queue_depth]
    desc_t mem [mem_depth];

    ptr_t    wr_ptr   [num_of_priorities];
    ptr_t    rd_ptr   [num_of_priorities];
    ptr_t    wr_ptr_n [num_of_priorities];
    ptr_t    rd_ptr_n [num_of_priorities];
    credit_t credit     [num_of_priorities];
    credit_t credit_n   [num_of_priorities];
    credit_t credit_eff [num_of_priorities];

    logic [priority_width-1:0]    rr_ptr;
    logic [priority_width-1:0]    rr_ptr_n;
    logic                         mode_q;

    logic [num_of_priorities-1:0] nonempty;
    logic [num_of_priorities-1:0] eligible;
    logic [num_of_priorities-1:0] full_n;
    logic [num_of_priorities-1:0] almost_full_n;
    logic                         prepared_n;
    logic                         any_eligible;
    logic                         enq_fire;
    logic                         deq_fire;
    logic                         wrr_start;
    logic [priority_width-1:0]    sp_sel;
    logic [priority_width-1:0]    wrr_sel;
    logic [priority_width-1:0]    sel;
    logic [idx_width-1:0]         wr_idx;
    logic [idx_width-1:0]         rd_idx;
    desc_t                        enq_desc;
    desc_t                        head;

    // Occupancy from the registered pointers (count != 0 <=> pointers differ)
    always_comb begin
        for (int p = 0; p < num_of_priorities; p++) begin
            nonempty[p] = (wr_ptr[p] != rd_ptr[p]);
        end
    end

    // A full queue drops the enqueue even if it is being drained this cycle
    assign enq_ready = !full[enq_priority];
    assign enq_fire  = enq_vld && !full[enq_priority];
    assign deq_fire  = deq_req && prepared;

    // First WRR cycle after strict-priority mode starts from empty credits
    assign wrr_start = sp0_wrr1 && !mode_q;

    // Strict priority: highest-index non-empty queue
    always_comb begin
        sp_sel = '0;
        for (int p = 0; p < num_of_priorities; p++) begin
            if (nonempty[p]) begin
                sp_sel = priority_width'(p);
            end
        end
    end

    // WRR pick: downward wrapping scan from rr_ptr over eligible queues, or,
    // when every credit is spent, from rr_ptr-1 over non-empty queues (the
    // credits are reloaded in the same decision).
    always_comb begin
        logic [priority_width-1:0]    idx;
        logic                         found;
        logic [num_of_priorities-1:0] cand;
        idx     = '0;
        found   = 1'b0;
        wrr_sel = rr_ptr;
        for (int p = 0; p < num_of_priorities; p++) begin
            credit_eff[p] = wrr_start ? '0 : credit[p];
            eligible[p]   = nonempty[p] && (credit_eff[p] != '0);
        end
        any_eligible = |eligible;
        cand = any_eligible ? eligible : nonempty;
        for (int i = 0; i < num_of_priorities; i++) begin
            idx = any_eligible ? rr_ptr - priority_width'(i)
                               : rr_ptr - priority_width'(i + 1);
            if (!found && cand[idx]) begin
                found   = 1'b1;
                wrr_sel = idx;
            end
        end
    end

    assign sel      = sp0_wrr1 ? wrr_sel : sp_sel;
    assign wr_idx   = {enq_priority, wr_ptr[enq_priority][depth_width-1:0]};
    assign rd_idx   = {sel, rd_ptr[sel][depth_width-1:0]};
    assign head     = mem[rd_idx];
    assign enq_desc = '{address: enq_address, length: enq_length};

    // Next pointers, credits and flags
    always_comb begin
        ptr_t    cnt;
        credit_t w;
        cnt        = '0;
        w          = '0;
        wr_ptr_n   = wr_ptr;
        rd_ptr_n   = rd_ptr;
        credit_n   = credit;
        rr_ptr_n   = rr_ptr;
        prepared_n = 1'b0;

        if (enq_fire) begin
            wr_ptr_n[enq_priority] = wr_ptr[enq_priority] + ptr_width'(1);
        end
        if (deq_fire) begin
            rd_ptr_n[sel] = rd_ptr[sel] + ptr_width'(1);
        end

        // Credits and rr_ptr are frozen while in strict-priority mode
        if (sp0_wrr1) begin
            credit_n = credit_eff;
            if (deq_fire) begin
                if (!any_eligible) begin
                    for (int p = 0; p < num_of_priorities; p++) begin
                        w = wrr_weight[p*wrr_weight_width +: wrr_weight_width];
                        credit_n[p] = (w == '0) ? credit_t'(1) : w;
                    end
                end
                credit_n[sel] = credit_n[sel] - credit_t'(1);
                rr_ptr_n      = sel;
            end
        end

        for (int p = 0; p < num_of_priorities; p++) begin
            cnt              = wr_ptr_n[p] - rd_ptr_n[p];
            full_n[p]        = (cnt == ptr_width'(queue_depth));
            almost_full_n[p] = (cnt >= ptr_width'(queue_depth - almost_full_margin));
            prepared_n       = prepared_n | (cnt != '0);
        end
    end

    // Control state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < num_of_priorities; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                credit[p] <= '0;
            end
            rr_ptr       <= '0;
            mode_q       <= 1'b0;
            overflow     <= 1'b0;
            deq_vld      <= 1'b0;
            deq_address  <= '0;
            deq_length   <= '0;
            deq_priority <= '0;
            prepared     <= 1'b0;
            full         <= '0;
            almost_full  <= '0;
        end else begin
            wr_ptr      <= wr_ptr_n;
            rd_ptr      <= rd_ptr_n;
            credit      <= credit_n;
            rr_ptr      <= rr_ptr_n;
            mode_q      <= sp0_wrr1;
            overflow    <= enq_vld && full[enq_priority];
            deq_vld     <= deq_fire;
            prepared    <= prepared_n;
            full        <= full_n;
            almost_full <= almost_full_n;
            if (deq_fire) begin
                deq_address  <= head.address;
                deq_length   <= head.length;
                deq_priority <= sel;
            end
        end
    end

    // Descriptor storage is not reset; pointers make stale rows unreachable
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem[wr_idx] <= enq_desc;
        end
    end

endmodule

// File: tb/tb_port_desc_queue.sv
// Bench for port_desc_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_port_desc_queue;

    localparam int NP    = 8;
    localparam int PW    = 3;
    localparam int AW    = 17;
    localparam int LW    = 8;
    localparam int DEPTH = 16;
    localparam int WW    = 5;
    localparam int AFM   = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           sp0_wrr1 = 1'b0;
    logic [NP*WW-1:0] wrr_weight = '0;
    logic           enq_vld = 1'b0;
    logic [PW-1:0]  enq_priority = '0;
    logic [AW-1:0]  enq_address = '0;
    logic [LW-1:0]  enq_length = '0;
    logic           enq_ready;
    logic           overflow;
    logic           deq_req = 1'b0;
    logic           deq_vld;
    logic [AW-1:0]  deq_address;
    logic [LW-1:0]  deq_length;
    logic [PW-1:0]  deq_priority;
    logic           prepared;
    logic [NP-1:0]  full;
    logic [NP-1:0]  almost_full;

    port_desc_queue dut (
        .clk(clk), .rst(rst), .sp0_wrr1(sp0_wrr1), .wrr_weight(wrr_weight),
        .enq_vld(enq_vld), .enq_priority(enq_priority), .enq_address(enq_address),
        .enq_length(enq_length), .enq_ready(enq_ready), .overflow(overflow),
        .deq_req(deq_req), .deq_vld(deq_vld), .deq_address(deq_address),
        .deq_length(deq_length), .deq_priority(deq_priority), .prepared(prepared),
        .full(full), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [AW-1:0] a;
        logic [LW-1:0] l;
    } d_t;

    d_t            mq [NP][$];
    int            credit [NP];
    int            rr = 0;
    bit            prev_mode = 1'b0;
    bit            exp_vld = 1'b0;
    bit            exp_ovf = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [LW-1:0] exp_len = '0;
    int            exp_pri = 0;

    always @(posedge clk or negedge rst) begin
        int sel;
        bit any;
        int w;
        d_t d;
        if (!rst) begin
            for (int p = 0; p < NP; p++) begin
                mq[p].delete();
                credit[p] = 0;
            end
            rr = 0;
            prev_mode = 1'b0;
            exp_vld = 1'b0;
            exp_ovf = 1'b0;
            exp_addr = '0;
            exp_len = '0;
            exp_pri = 0;
        end else begin
            exp_ovf = enq_vld && (mq[enq_priority].size() == DEPTH);
            exp_vld = 1'b0;
            any = 1'b0;
            for (int p = 0; p < NP; p++) if (mq[p].size() > 0) any = 1'b1;
            if (sp0_wrr1 && !prev_mode)
                for (int p = 0; p < NP; p++) credit[p] = 0;
            if (deq_req && any) begin
                sel = -1;
                if (!sp0_wrr1) begin
                    for (int p = NP - 1; p >= 0; p--)
                        if (sel < 0 && mq[p].size() > 0) sel = p;
                end else begin
                    for (int k = 0; k < NP; k++) begin
                        int p;
                        p = (rr - k + NP) % NP;
                        if (sel < 0 && mq[p].size() > 0 && credit[p] > 0) sel = p;
                    end
                    if (sel < 0) begin
                        for (int p = 0; p < NP; p++) begin
                            w = int'(wrr_weight[p*WW +: WW]);
                            credit[p] = (w == 0) ? 1 : w;
                        end
                        for (int k = 0; k < NP; k++) begin
                            int p;
                            p = (rr - 1 - k + 2 * NP) % NP;
                            if (sel < 0 && mq[p].size() > 0) sel = p;
                        end
                    end
                    credit[sel] = credit[sel] - 1;
                    rr = sel;
                end
                d = mq[sel].pop_front();
                exp_vld = 1'b1;
                exp_addr = d.a;
                exp_len = d.l;
                exp_pri = sel;
            end
            if (enq_vld && !exp_ovf) begin
                d.a = enq_address;
                d.l = enq_length;
                mq[enq_priority].push_back(d);
            end
            prev_mode = sp0_wrr1;
        end
    end

    // ---------------- per-cycle compare ----------------
    int            got_pri [$];
    logic [AW-1:0] got_addr [$];

    always @(negedge clk) begin
        logic [NP-1:0] ef;
        logic [NP-1:0] ea;
        bit            ep;
        ep = 1'b0;
        for (int p = 0; p < NP; p++) begin
            ef[p] = (mq[p].size() == DEPTH);
            ea[p] = (mq[p].size() >= DEPTH - AFM);
            if (mq[p].size() > 0) ep = 1'b1;
        end
        chk("deq_vld", 32'(deq_vld), 32'(exp_vld));
        if (exp_vld) begin
            chk("deq_address", 32'(deq_address), 32'(exp_addr));
            chk("deq_length", 32'(deq_length), 32'(exp_len));
            chk("deq_priority", 32'(deq_priority), 32'(exp_pri));
        end
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        chk("prepared", 32'(prepared), 32'(ep));
        chk("full", 32'(full), 32'(ef));
        chk("almost_full", 32'(almost_full), 32'(ea));
        chk("enq_ready", 32'(enq_ready), 32'(mq[enq_priority].size() != DEPTH));
        if (deq_vld) begin
            got_pri.push_back(int'(deq_priority));
            got_addr.push_back(deq_address);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit ev, input int ep, input int ea, input int el, input bit dr);
        enq_vld      = ev;
        enq_priority = PW'(ep);
        enq_address  = AW'(ea);
        enq_length   = LW'(el);
        deq_req      = dr;
        cyc();
        enq_vld = 1'b0;
        deq_req = 1'b0;
    endtask

    task automatic do_reset();
        enq_vld = 1'b0;
        deq_req = 1'b0;
        rst = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    task automatic set_weight(input int p, input int w);
        wrr_weight[p*WW +: WW] = WW'(w);
    endtask

    task automatic wrr_setup();
        do_reset();
        wrr_weight = '0;
        set_weight(7, 2);
        set_weight(6, 1);
        sp0_wrr1 = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 7, 'h700 + i, i, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 6, 'h600 + i, i, 1'b0);
        got_pri.delete();
        got_addr.delete();
    endtask

    int exp_seq [8] = '{7, 7, 6, 7, 7, 6, 6, 6};
    int t3_addr [3] = '{'h50, 'h51, 'h10};
    int t3_pri  [3] = '{5, 5, 1};

    initial begin
        cyc();
        cyc();
        rst = 1'b1;
        cyc();

        // Fill p3 past capacity, then drain
        do_reset();
        sp0_wrr1 = 1'b0;
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 3, i, i, 1'b0);
            if (i == 12) chk("t2_af_13", 32'(almost_full[3]), 32'd0);
            if (i == 13) chk("t2_af_14", 32'(almost_full[3]), 32'd1);
            if (i == 14) chk("t2_full_15", 32'(full[3]), 32'd0);
            if (i == 15) begin
                chk("t2_full_16", 32'(full[3]), 32'd1);
                chk("t2_ready_16", 32'(enq_ready), 32'd0);
            end
            if (i == 16) chk("t2_ovf_pulse", 32'(overflow), 32'd1);
        end
        cyc();
        chk("t2_ovf_single", 32'(overflow), 32'd0);
        chk("t2_still_full", 32'(full[3]), 32'd1);
        got_addr.delete();
        got_pri.delete();
        for (int i = 0; i < 16; i++) step(1'b0, 0, 0, 0, 1'b1);
        cyc();
        chk("t2_deq_count", 32'(got_addr.size()), 32'd16);
        for (int i = 0; i < 16; i++)
            if (i < got_addr.size()) chk($sformatf("t2_addr%0d", i), 32'(got_addr[i]), 32'(i));
        chk("t2_empty", 32'(prepared), 32'd0);

        // Strict priority ordering and latency
        do_reset();
        sp0_wrr1 = 1'b0;
        step(1'b1, 1, 'h10, 1, 1'b0);
        step(1'b1, 5, 'h50, 2, 1'b0);
        step(1'b1, 5, 'h51, 3, 1'b0);
        chk("t3_idle_vld", 32'(deq_vld), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 0, 0, 0, 1'b1);
            chk($sformatf("t3_vld%0d", k), 32'(deq_vld), 32'd1);
            chk($sformatf("t3_addr%0d", k), 32'(deq_address), 32'(t3_addr[k]));
            chk($sformatf("t3_pri%0d", k), 32'(deq_priority), 32'(t3_pri[k]));
        end

        // Same-cycle enqueue into an empty queue is not yet dequeueable
        do_reset();
        step(1'b1, 2, 'h1AB, 'h22, 1'b1);
        chk("t5_no_vld", 32'(deq_vld), 32'd0);
        chk("t5_prepared", 32'(prepared), 32'd1);
        step(1'b0, 0, 0, 0, 1'b1);
        chk("t5_vld", 32'(deq_vld), 32'd1);
        chk("t5_addr", 32'(deq_address), 32'h1AB);
        chk("t5_pri", 32'(deq_priority), 32'd2);

        // WRR weights 7:2, 6:1
        wrr_setup();
        for (int k = 0; k < 8; k++) step(1'b0, 0, 0, 0, 1'b1);
        cyc();
        chk("t4_count", 32'(got_pri.size()), 32'd8);
        for (int k = 0; k < 8; k++)
            if (k < got_pri.size()) chk($sformatf("t4_pri%0d", k), 32'(got_pri[k]), 32'(exp_seq[k]));

        // Mode switch in the middle of the WRR sequence
        wrr_setup();
        for (int k = 0; k < 3; k++) step(1'b0, 0, 0, 0, 1'b1);
        sp0_wrr1 = 1'b0;
        step(1'b0, 0, 0, 0, 1'b1);
        chk("t6_sp_pri", 32'(deq_priority), 32'd7);
        sp0_wrr1 = 1'b1;
        for (int k = 0; k < 4; k++) step(1'b0, 0, 0, 0, 1'b1);
        cyc();
        chk("t6_count", 32'(got_pri.size()), 32'd8);
        for (int k = 0; k < 8; k++)
            if (k < got_pri.size()) chk($sformatf("t6_pri%0d", k), 32'(got_pri[k]), 32'(exp_seq[k]));

        // Randomized traffic
        do_reset();
        for (int ph = 0; ph < 4; ph++) begin
            int enq_pct;
            int deq_pct;
            for (int p = 0; p < NP; p++) set_weight(p, int'($urandom_range(0, 3)));
            enq_pct = (ph == 1) ? 90 : 60;
            deq_pct = (ph == 1) ? 25 : 55;
            for (int c = 0; c < 600; c++) begin
                if ($urandom_range(0, 31) == 0) sp0_wrr1 = ~sp0_wrr1;
                enq_vld      = ($urandom_range(0, 99) < enq_pct);
                enq_priority = (ph == 2) ? PW'($urandom_range(5, 7)) : PW'($urandom_range(0, 7));
                enq_address  = AW'($urandom);
                enq_length   = LW'($urandom);
                deq_req      = ($urandom_range(0, 99) < deq_pct);
                cyc();
            end
        end

        // Reset asserted mid-run
        enq_vld = 1'b1;
        enq_priority = 3'd4;
        rst = 1'b0;
        #1;
        chk("t1_deq_vld", 32'(deq_vld), 32'd0);
        chk("t1_deq_address", 32'(deq_address), 32'd0);
        chk("t1_deq_priority", 32'(deq_priority), 32'd0);
        chk("t1_overflow", 32'(overflow), 32'd0);
        chk("t1_prepared", 32'(prepared), 32'd0);
        chk("t1_full", 32'(full), 32'd0);
        chk("t1_almost_full", 32'(almost_full), 32'd0);
        chk("t1_enq_ready", 32'(enq_ready), 32'd1);
        enq_vld = 1'b0;
        cyc();
        rst = 1'b1;
        step(1'b0, 0, 0, 0, 1'b1);
        chk("t1_deq_after_rst", 32'(deq_vld), 32'd0);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
